// File: rtl/dsp_inst_mem.sv
// Instruction memory for the DSP core with a byte-serial program loader.
// Fetch reads are combinational; the loader assembles MSB-first bytes into
// words, writes them sequentially from word 0 and holds the fetch stage in
// reset until a complete image has been loaded.
//
// Handshake: a load byte is transferred on a rising edge where load_valid and
// load_ready are both high; load_ready is high only in LOAD, and a cycle
// without that pair changes nothing. load_last is sampled only with a transfer.

`ifndef INST_WORD_LEN
`define INST_WORD_LEN 32
`endif
`ifndef MEM_ADDR_LEN
`define MEM_ADDR_LEN 16
`endif

module dsp_inst_mem #(
  parameter int WORD_W = `INST_WORD_LEN,
  parameter int ADDR_W = `MEM_ADDR_LEN,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WORD_W-1:0] read_data,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              fetch_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [1:0]        dbg_state
);

  localparam int BYTES = WORD_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W:0] DEPTH_P   = (ADDR_W + 1)'(DEPTH);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Storage has no reset so a program survives a core reset.
  logic [WORD_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              fetch_hold_q, fetch_hold_d;
  logic              load_ready_q, load_ready_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              accept;
  logic              mem_full;
  logic              word_end;
  logic              mem_we;
  logic [WORD_W-1:0] asm_next;

  // Combinational fetch; addresses past the populated depth read as zero.
  always_comb begin
    read_data = '0;
    if ({1'b0, read_addr} < DEPTH_P) begin
      read_data = mem[read_addr[IDX_W-1:0]];
    end
  end

  // Loader next-state: restart, byte assembly, word write and termination.
  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    mem_we   = 1'b0;
    asm_next = (asm_q << 8) | WORD_W'(load_byte);
    accept   = (state_q == S_LOAD) && load_valid;
    mem_full = (wptr_q == DEPTH_P);
    word_end = (bcnt_q == LAST_BYTE);

    if (load_start) begin
      // Restart from any state; a byte offered in this cycle is dropped.
      state_d = S_LOAD;
      wptr_d  = '0;
      bcnt_d  = '0;
      asm_d   = '0;
    end else if (accept) begin
      if (mem_full) begin
        state_d = S_ERR;
      end else if (word_end) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + (ADDR_W + 1)'(1);
        bcnt_d = '0;
        asm_d  = '0;
        if (load_last) begin
          state_d = S_DONE;
        end
      end else if (load_last) begin
        // Image ended mid-word: the partial word is thrown away.
        state_d = S_ERR;
        bcnt_d  = '0;
        asm_d   = '0;
      end else begin
        asm_d  = asm_next;
        bcnt_d = bcnt_q + BC_W'(1);
      end
    end

    // Status outputs are decoded from the next state and registered.
    fetch_hold_d = (state_d != S_DONE);
    load_ready_d = (state_d == S_LOAD);
    load_done_d  = (state_d == S_DONE);
    load_err_d   = (state_d == S_ERR);
  end

  // Loader state and registered status with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      fetch_hold_q <= 1'b1;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      fetch_hold_q <= fetch_hold_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Word write; suppressed while reset is asserted so a load cut short
  // by reset never commits its word.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[wptr_q[IDX_W-1:0]] <= asm_next;
    end
  end

  assign load_ready   = load_ready_q;
  assign fetch_hold   = fetch_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = wptr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dsp_inst_mem.sv
// Self-checking bench for dsp_inst_mem (32-bit words, 16-deep memory).
// A byte-level behavioural model tracks the expected image, outcome and
// status outputs; directed scenarios are followed by randomized loads.
`timescale 1ns/1ps

module tb_dsp_inst_mem;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;

  // Model outcome codes
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] read_addr;
  logic [WORD_W-1:0] read_data;
  logic              load_start;
  logic [7:0]        load_byte;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              fetch_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WORD_W-1:0] exp_mem [DEPTH];
  bit                exp_vld [DEPTH];
  int                m_state;
  int                m_wp;
  int                m_cnt;
  logic [WORD_W-1:0] m_word;

  dsp_inst_mem #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .load_start  (load_start),
    .load_byte   (load_byte),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .fetch_hold  (fetch_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_start();
    m_state = M_LOAD;
    m_wp    = 0;
    m_cnt   = 0;
    m_word  = '0;
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_wp    = 0;
    m_cnt   = 0;
    m_word  = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit last);
    if (m_state != M_LOAD) return;
    if (m_wp == DEPTH) begin
      m_state = M_ERR;
      return;
    end
    m_word = m_word * 256 + WORD_W'(b);
    m_cnt++;
    if (m_cnt == WORD_W / 8) begin
      exp_mem[m_wp] = m_word;
      exp_vld[m_wp] = 1'b1;
      m_wp++;
      m_cnt  = 0;
      m_word = '0;
      if (last) m_state = M_DONE;
    end else if (last) begin
      m_state = M_ERR;
      m_cnt   = 0;
      m_word  = '0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic do_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_start();
    check_status("start");
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit last, input int idle);
    load_valid = 1'b0;
    repeat (idle) @(negedge clk);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = $urandom_range(0, 255);
    model_byte(b, last);
  endtask

  // ---------------- checkers ----------------
  task automatic check_status(input string tag);
    check_eq({tag, "_fetch_hold"}, 64'(fetch_hold), 64'(m_state != M_DONE));
    check_eq({tag, "_load_ready"}, 64'(load_ready), 64'(m_state == M_LOAD));
    check_eq({tag, "_load_done"},  64'(load_done),  64'(m_state == M_DONE));
    check_eq({tag, "_load_err"},   64'(load_err),   64'(m_state == M_ERR));
    check_eq({tag, "_words"},      64'(words_loaded), 64'(m_wp));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_vld[i]) begin
        read_addr = ADDR_W'(i);
        #1;
        check_eq($sformatf("%s_mem%0d", tag, i), 64'(read_data), 64'(exp_mem[i]));
        @(negedge clk);
      end
    end
    read_addr = ADDR_W'(20);
    #1;
    check_eq({tag, "_oob_read"}, 64'(read_data), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] t1_bytes [8];
    logic [WORD_W-1:0] keep1;
    int n;
    bit use_last;

    t1_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    for (int i = 0; i < DEPTH; i++) begin
      exp_vld[i] = 1'b0;
      exp_mem[i] = '0;
    end
    rst        = 1'b0;
    read_addr  = '0;
    load_start = 1'b0;
    load_byte  = '0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_status("reset");
    read_addr = ADDR_W'(20);
    #1;
    check_eq("reset_oob_read", 64'(read_data), 64'(0));
    @(negedge clk);

    // Two-word image, back-to-back bytes
    do_start();
    for (int i = 0; i < 8; i++) drive_byte(t1_bytes[i], i == 7, 0);
    check_status("two_word");
    read_addr = ADDR_W'(1);
    #1;
    check_eq("two_word_addr1_same_cycle", 64'(read_data), 64'h0000_0000_ABCD_EF01);
    read_addr = ADDR_W'(0);
    #1;
    check_eq("two_word_addr0", 64'(read_data), 64'h0000_0000_1234_5678);
    @(negedge clk);
    check_mem("two_word");

    // One word with load_valid toggling every cycle
    do_start();
    for (int i = 0; i < 4; i++) drive_byte($urandom_range(0, 255), i == 3, 1);
    check_status("gapped");
    check_mem("gapped");

    // load_last on the third byte: partial word discarded
    do_start();
    for (int i = 0; i < 3; i++) drive_byte($urandom_range(0, 255), i == 2, 0);
    check_status("short_last");
    drive_byte(8'h5A, 1'b1, 0);
    check_status("short_last_ignored");
    check_mem("short_last");

    // Fill the memory, then overflow
    do_start();
    for (int i = 0; i < 64; i++) drive_byte($urandom_range(0, 255), 1'b0, 0);
    check_status("full");
    drive_byte($urandom_range(0, 255), 1'b0, 0);
    check_status("overflow");
    check_mem("overflow");

    // Reset in the middle of the second word
    keep1 = exp_mem[1];
    do_start();
    for (int i = 0; i < 6; i++) drive_byte($urandom_range(0, 255), 1'b0, 0);
    do_reset();
    check_status("mid_reset");
    read_addr = ADDR_W'(1);
    #1;
    check_eq("mid_reset_mem1_kept", 64'(read_data), 64'(keep1));
    check_mem("mid_reset");

    // Reload from DONE: fetch_hold reasserts, untouched words persist
    do_start();
    for (int i = 0; i < 8; i++) drive_byte($urandom_range(0, 255), i == 7, 0);
    check_status("pre_reload");
    keep1 = exp_mem[1];
    do_start();
    for (int i = 0; i < 4; i++) drive_byte($urandom_range(0, 255), i == 3, 0);
    check_status("reload");
    read_addr = ADDR_W'(1);
    #1;
    check_eq("reload_mem1_kept", 64'(read_data), 64'(keep1));
    check_mem("reload");

    // Restart while loading with a byte offered in the restart cycle
    do_start();
    drive_byte(8'hDE, 1'b0, 0);
    drive_byte(8'hAD, 1'b0, 0);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'hFF;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    model_start();
    check_status("restart");
    drive_byte(8'hC0, 1'b0, 0);
    drive_byte(8'hFF, 1'b0, 0);
    drive_byte(8'hEE, 1'b0, 0);
    drive_byte(8'h42, 1'b1, 0);
    check_status("restart_done");
    read_addr = '0;
    #1;
    check_eq("restart_mem0", 64'(read_data), 64'h0000_0000_C0FF_EE42);
    @(negedge clk);

    // Randomized loads
    for (int it = 0; it < 20; it++) begin
      do_start();
      n = $urandom_range(1, 24);
      use_last = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n; i++) begin
        drive_byte($urandom_range(0, 255), use_last && (i == n - 1), $urandom_range(0, 2));
      end
      if ($urandom_range(0, 4) == 0) do_reset();
      check_status($sformatf("rand%0d", it));
      check_mem($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
